rx_interleave: RTL and testbench

Downstream of the channel selector/decimation strobe in the receive path. On each decimation strobe it captures one I/Q sample per active channel and serialises the set into the RX sample FIFO as 16-bit words: I0, Q0, I1, Q1, …. It handles FIFO backpressure by stalling. It detects and counts frames lost when a new strobe arrives before the previous set has drained.

---
 rtl/rx_interleave_pkg.sv | 19 +
 rtl/rx_interleave.sv | 100 ++++++++++
 tb/tb_rx_interleave.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_interleave_pkg.sv
// Shared receive-path definitions: channel-select encoding and sample/FIFO word widths.
// The channel selector uses the same encoding.
package rx_interleave_pkg;

    localparam int FIFO_W     = 16;
    localparam int DW_DEFAULT = FIFO_W;
    localparam int CH_SEL_W   = 3;

    // Active channels minus one: 0 selects one channel.
    typedef logic [CH_SEL_W-1:0] ch_sel_t;

    // Limit a requested channel selection to the channels physically present.
    function automatic ch_sel_t clamp_ch(input ch_sel_t sel, input int num_ch);
        if (int'(sel) > num_ch - 1)
            return ch_sel_t'(num_ch - 1);
        return sel;
    endfunction

endpackage

// File: rtl/rx_interleave.sv
// Captures one I/Q sample per active channel on each decimation strobe and
// serialises them into the RX FIFO as I0,Q0,I1,Q1,... with stall-on-full and overrun counting.
module rx_interleave
    import rx_interleave_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strobe,
    input  ch_sel_t              channels,
    input  logic [NUM_CH*DW-1:0] ch_i,
    input  logic [NUM_CH*DW-1:0] ch_q,
    input  logic                 fifo_full,
    input  logic                 clear_status,
    output logic [DW-1:0]        fifo_data,
    output logic                 fifo_we,
    output logic                 busy,
    output logic                 overrun,
    output logic [15:0]          overrun_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state;
    logic [NUM_CH*DW-1:0] shadow_i;
    logic [NUM_CH*DW-1:0] shadow_q;
    ch_sel_t              last_idx;
    ch_sel_t              idx;
    logic                 phase;
    logic [DW-1:0]        word;
    logic                 issue;
    logic                 final_word;
    logic                 accept;
    logic                 drop;

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == ch_sel_t'(k))
                word = phase ? shadow_q[k*DW +: DW] : shadow_i[k*DW +: DW];
        end
    end

    // A strobe landing on the cycle the final Q goes out starts the next frame back-to-back.
    assign issue      = (state == EMIT) && !fifo_full;
    assign final_word = phase && (idx == last_idx);
    assign accept     = strobe && ((state == IDLE) || (issue && final_word));
    assign drop       = strobe && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shadow_i      <= '0;
            shadow_q      <= '0;
            last_idx      <= '0;
            idx           <= '0;
            phase         <= 1'b0;
            fifo_data     <= '0;
            fifo_we       <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            fifo_we <= issue;
            if (issue)
                fifo_data <= word;
            busy <= (state == EMIT);

            if (accept) begin
                shadow_i <= ch_i;
                shadow_q <= ch_q;
                last_idx <= clamp_ch(channels, NUM_CH);
                idx      <= '0;
                phase    <= 1'b0;
                state    <= EMIT;
            end else if (issue) begin
                if (final_word) begin
                    state <= IDLE;
                end else if (phase) begin
                    phase <= 1'b0;
                    idx   <= idx + 1'b1;
                end else begin
                    phase <= 1'b1;
                end
            end

            if (clear_status) begin
                overrun       <= 1'b0;
                overrun_count <= '0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (overrun_count != 16'hFFFF)
                    overrun_count <= overrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_interleave.sv
// Directed self-checking bench for rx_interleave (NUM_CH=4, DW=16).
module tb_rx_interleave;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 strobe;
    logic [2:0]           channels;
    logic [NUM_CH*DW-1:0] ch_i;
    logic [NUM_CH*DW-1:0] ch_q;
    logic                 fifo_full;
    logic                 clear_status;
    logic [DW-1:0]        fifo_data;
    logic                 fifo_we;
    logic                 busy;
    logic                 overrun;
    logic [15:0]          overrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        strobe;
        logic [2:0]  channels;
        logic        full;
        logic        we;
        logic [15:0] data;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    rx_interleave #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .channels(channels),
        .ch_i(ch_i), .ch_q(ch_q), .fifo_full(fifo_full), .clear_status(clear_status),
        .fifo_data(fifo_data), .fifo_we(fifo_we), .busy(busy),
        .overrun(overrun), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic [2:0] c, input logic f,
                       input logic w, input logic [15:0] d, input logic b);
        vecs.push_back('{strobe: s, channels: c, full: f, we: w, data: d, busy: b});
    endtask

    // Channel k of frame f carries I = 0x0A+k+0x100*f, Q = 0x1A+k+0x100*f.
    task automatic set_data(input int f);
        for (int k = 0; k < NUM_CH; k++) begin
            ch_i[k*DW +: DW] = 16'(16'h0A + k + 16'h100 * f);
            ch_q[k*DW +: DW] = 16'(16'h1A + k + 16'h100 * f);
        end
    endtask

    function automatic logic [15:0] exp_word(input int f, input int j);
        return 16'(((j % 2) != 0 ? 16'h1A : 16'h0A) + j / 2 + 16'h100 * f);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; strobe = 1'b0; channels = 3'd1; fifo_full = 1'b0; clear_status = 1'b0;
        set_data(0);
        tick(); tick();
        check("rst_we", fifo_we, 0);
        check("rst_data", fifo_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_count", overrun_count, 0);
        reset = 1'b1;
        tick();

        // Plain 4-word frame.
        add(1, 1, 0, 0, 16'h0,  0);
        add(0, 1, 0, 1, 16'h0A, 1);
        add(0, 1, 0, 1, 16'h1A, 1);
        add(0, 1, 0, 1, 16'h0B, 1);
        add(0, 1, 0, 1, 16'h1B, 1);
        add(0, 1, 0, 0, 16'h0,  0);
        add(0, 1, 0, 0, 16'h0,  0);
        // Three stall cycles after the second word.
        add(1, 1, 0, 0, 16'h0,  0);
        add(0, 1, 0, 1, 16'h0A, 1);
        add(0, 1, 0, 1, 16'h1A, 1);
        add(0, 1, 1, 0, 16'h0,  1);
        add(0, 1, 1, 0, 16'h0,  1);
        add(0, 1, 1, 0, 16'h0,  1);
        add(0, 1, 0, 1, 16'h0B, 1);
        add(0, 1, 0, 1, 16'h1B, 1);
        add(0, 1, 0, 0, 16'h0,  0);
        // channels=7 clamps to four channels; changing channels mid-frame is ignored.
        add(1, 7, 0, 0, 16'h0,  0);
        add(0, 0, 0, 1, 16'h0A, 1);
        add(0, 0, 0, 1, 16'h1A, 1);
        add(0, 0, 0, 1, 16'h0B, 1);
        add(0, 0, 0, 1, 16'h1B, 1);
        add(0, 0, 0, 1, 16'h0C, 1);
        add(0, 0, 0, 1, 16'h1C, 1);
        add(0, 0, 0, 1, 16'h0D, 1);
        add(0, 0, 0, 1, 16'h1D, 1);
        add(0, 0, 0, 0, 16'h0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            strobe = vecs[i].strobe; channels = vecs[i].channels; fifo_full = vecs[i].full;
            tick();
            check($sformatf("vec%0d_we", i), fifo_we, vecs[i].we);
            if (vecs[i].we)
                check($sformatf("vec%0d_data", i), fifo_data, vecs[i].data);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
        end
        strobe = 1'b0; fifo_full = 1'b0; channels = 3'd1;

        // Strobe period 4: continuous writes, fresh data per frame.
        for (int e = 0; e <= 20; e++) begin
            strobe = (e % 4 == 0) && (e < 20);
            if (strobe) set_data(e / 4);
            tick();
            if (e >= 1) begin
                check($sformatf("p4_we%0d", e), fifo_we, 1);
                check($sformatf("p4_data%0d", e), fifo_data, exp_word((e - 1) / 4, (e - 1) % 4));
            end
        end
        strobe = 1'b0;
        tick();
        check("p4_we_end", fifo_we, 0);
        check("p4_overrun", overrun, 0);
        check("p4_count", overrun_count, 0);

        // Strobe period 3: every other strobe dropped.
        set_data(0);
        for (int e = 0; e <= 17; e++) begin
            strobe = (e % 3 == 0) && (e <= 15);
            tick();
            if (e % 3 == 0 && e <= 15)
                check($sformatf("p3_count%0d", e), overrun_count, ((e / 3) + 1) / 2);
        end
        strobe = 1'b0;
        check("p3_overrun", overrun, 1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_count", overrun_count, 0);

        // Strobe on the final-word cycle while full is an overrun; shadow keeps old frame.
        set_data(0);
        strobe = 1'b1; tick();
        strobe = 1'b0; tick(); tick(); tick();
        check("fw_data3", fifo_data, 16'h0B);
        set_data(7);
        strobe = 1'b1; fifo_full = 1'b1; tick();
        check("fw_we_stall", fifo_we, 0);
        check("fw_count", overrun_count, 1);
        check("fw_overrun", overrun, 1);
        strobe = 1'b0; fifo_full = 1'b0; tick();
        check("fw_we_last", fifo_we, 1);
        check("fw_data_last", fifo_data, 16'h1B);
        tick();
        check("fw_we_idle", fifo_we, 0);
        check("fw_busy_idle", busy, 0);

        // Saturation: hold the FIFO full and strobe every cycle.
        clear_status = 1'b1; tick(); clear_status = 1'b0;
        strobe = 1'b1; tick();
        fifo_full = 1'b1;
        repeat (65538) @(posedge clk);
        #1;
        check("sat_count", overrun_count, 16'hFFFF);
        check("sat_overrun", overrun, 1);
        clear_status = 1'b1; tick();
        check("clr_drop_count", overrun_count, 0);
        check("clr_drop_overrun", overrun, 0);
        clear_status = 1'b0; tick();
        check("drop_after_clr", overrun_count, 1);
        strobe = 1'b0; clear_status = 1'b1; tick();
        clear_status = 1'b0;
        check("clr_again", overrun_count, 0);
        fifo_full = 1'b0;
        repeat (6) tick();
        check("drain_we", fifo_we, 0);
        check("drain_busy", busy, 0);

        // Reset during the third word of a frame.
        set_data(0);
        strobe = 1'b1; tick();
        strobe = 1'b0; tick(); tick(); tick();
        check("mid_we", fifo_we, 1);
        check("mid_data", fifo_data, 16'h0B);
        #1 reset = 1'b0;
        #1;
        check("arst_we", fifo_we, 0);
        check("arst_data", fifo_data, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_count", overrun_count, 0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post_rst_we%0d", c), fifo_we, 0);
            check($sformatf("post_rst_busy%0d", c), busy, 0);
        end
        set_data(3);
        strobe = 1'b1; tick();
        check("fresh_we0", fifo_we, 0);
        strobe = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("fresh_we%0d", j + 1), fifo_we, 1);
            check($sformatf("fresh_data%0d", j + 1), fifo_data, exp_word(3, j));
        end
        tick();
        check("fresh_we_end", fifo_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
